mrfm_mac_scheduler: RTL

Round-robin scheduler that shares one external signed 16x16 multiplier and one 34-bit accumulator among up to NREQ requesters, each needing a dot product of up to 15 terms. Typical requesters are the MRFM compensator matrix rows and the loop filters. For each granted job the block:
- sequences operand fetch by term index;
- drives the multiplier inputs and the accumulator clear/enable;
- scales the final sum;
- returns a registered 16-bit result with a one-cycle done pulse.

---
 rtl/mrfm_mac_scheduler.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mrfm_mac_scheduler.sv
// Round-robin owner of one shared 16x16 multiplier and 34-bit accumulator; latency len+MULT_LAT+2 from req to done.
// Jobs run to completion once granted; MRFM_MAC_SAT_EN selects a saturating result instead of a 16-bit wrap.
module mrfm_mac_scheduler #(
    parameter int NREQ     = 4,
    parameter int MULT_LAT = 1
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [4*NREQ-1:0]      len_i,
    input  logic [16*NREQ-1:0]     data_in_i,
    input  logic [16*NREQ-1:0]     coeff_in_i,
    input  logic [7:0]             shift_i,
    output logic [NREQ-1:0]        grant_o,
    output logic [3:0]             term_idx_o,
    output logic [15:0]            mult_x_o,
    output logic [15:0]            mult_y_o,
    input  logic [30:0]            mult_product_i,
    output logic                   acc_clear_o,
    output logic                   acc_en_o,
    input  logic [33:0]            acc_sum_i,
    output logic [15:0]            result_o,
    output logic [NREQ-1:0]        done_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [NREQ-1:0]       grant_q, grant_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            term_q, term_d;
    logic [1:0]            drn_q, drn_d;
    logic [MULT_LAT-1:0]   vld_q, vld_d;
    logic [15:0]           result_q, result_d;
    logic [NREQ-1:0]       done_q, done_d;

    logic [NREQ-1:0]       elig;
    logic                  win_found;
    logic [PW-1:0]         win_idx;
    logic [NREQ-1:0]       win_oh;
    logic [3:0]            win_len;
    logic [15:0]           sel_data;
    logic [15:0]           sel_coeff;
    logic                  issue;
    logic [4:0]            sh_amt;
    logic signed [33:0]    shifted;
    logic [15:0]           scaled;
    logic                  unused_bits;

    // A requester in its own done cycle is skipped, so the next one can win that same cycle.
    always_comb begin
        int j;
        j         = 0;
        elig      = req_i & ~done_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = NREQ; off >= 1; off--) begin
            j = (int'(ptr_q) + off) % NREQ;
            for (int k = 0; k < NREQ; k++) begin
                if (k == j && elig[k]) begin
                    win_found = 1'b1;
                    win_idx   = PW'(k);
                end
            end
        end
    end

    always_comb begin
        win_oh    = '0;
        win_len   = '0;
        sel_data  = '0;
        sel_coeff = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == PW'(k)) begin
                win_oh[k] = 1'b1;
                win_len   = len_i[4*k +: 4];
            end
            if (ptr_q == PW'(k)) begin
                sel_data  = data_in_i[16*k +: 16];
                sel_coeff = coeff_in_i[16*k +: 16];
            end
        end
    end

    always_comb begin
        sh_amt  = (shift_i > 8'd18) ? 5'd18 : shift_i[4:0];
        shifted = $signed(acc_sum_i) >>> sh_amt;
`ifdef MRFM_MAC_SAT_EN
        if (shifted > 34'sd32767) begin
            scaled = 16'h7FFF;
        end else if (shifted < -34'sd32768) begin
            scaled = 16'h8000;
        end else begin
            scaled = shifted[15:0];
        end
`else
        scaled = shifted[15:0];
`endif
    end

    assign unused_bits = ^{mult_product_i, shifted[33:16]};

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        term_d      = term_q;
        drn_d       = drn_q;
        result_d    = result_q;
        done_d      = '0;
        acc_clear_o = 1'b0;
        mult_x_o    = '0;
        mult_y_o    = '0;
        issue       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    acc_clear_o = 1'b1;
                    grant_d     = win_oh;
                    ptr_d       = win_idx;
                    len_d       = win_len;
                    term_d      = '0;
                    drn_d       = '0;
                    state_d     = (win_len != 4'd0) ? S_ISSUE : S_DRAIN;
                end
            end
            S_ISSUE: begin
                issue    = 1'b1;
                mult_x_o = sel_data;
                mult_y_o = sel_coeff;
                if (term_q == len_q - 4'd1) begin
                    term_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    term_d = term_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (drn_q == 2'(MULT_LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drn_d = drn_q + 2'd1;
                end
            end
            S_DONE: begin
                result_d = scaled;
                done_d   = grant_q;
                grant_d  = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Valid tag travels alongside the operands so acc_en lines up with the product.
    assign vld_d = MULT_LAT'({vld_q, issue});

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            ptr_q    <= PW'(NREQ - 1);
            len_q    <= '0;
            term_q   <= '0;
            drn_q    <= '0;
            vld_q    <= '0;
            result_q <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            term_q   <= term_d;
            drn_q    <= drn_d;
            vld_q    <= vld_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign grant_o    = grant_q;
    assign term_idx_o = term_q;
    assign acc_en_o   = vld_q[MULT_LAT-1];
    assign result_o   = result_q;
    assign done_o     = done_q;

endmodule
